// File: rtl/decode_pkg.sv
// Shared encodings, control bundle and FSM state for the RV32 ID/EX decode stage.
package decode_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;
  localparam logic [2:0] IMM_C = 3'b101;

  localparam logic [2:0] ALU_R      = 3'b000;
  localparam logic [2:0] ALU_I      = 3'b001;
  localparam logic [2:0] ALU_ADD    = 3'b010;
  localparam logic [2:0] ALU_JALR   = 3'b011;
  localparam logic [2:0] ALU_B      = 3'b100;
  localparam logic [2:0] ALU_LUI    = 3'b101;
  localparam logic [2:0] ALU_MULDIV = 3'b110;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_JALR = 2'b01;
  localparam logic [1:0] BR_B    = 2'b10;
  localparam logic [1:0] BR_J    = 2'b11;

  // pc_to_reg_src: rd from the PC adder (pc+4 on jumps, pc+imm on AUIPC).
  // rd_src: rd from CSR read data. alu_src: operand B is the immediate.
  typedef struct packed {
    logic [2:0] imm_type;
    logic [2:0] alu_op;
    logic       pc_to_reg_src;
    logic       alu_src;
    logic       rd_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       csr_write;
    logic [1:0] branch;
    logic [2:0] funct3;
    logic       illegal;
  } ctrl_bundle_t;

  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_ISSUE} fsm_state_e;

  // A bubble keeps the datapath fields but must never change architectural state.
  function automatic ctrl_bundle_t bubble(input ctrl_bundle_t b);
    ctrl_bundle_t r;
    r            = b;
    r.mem_read   = 1'b0;
    r.mem_write  = 1'b0;
    r.mem_to_reg = 1'b0;
    r.reg_write  = 1'b0;
    r.csr_write  = 1'b0;
    r.branch     = BR_NONE;
    r.illegal    = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/inst_decoder.sv
// Combinational RV32I + SYSTEM decoder. Define DECODE_MEXT_EN to accept the
// M-extension encoding (OP with funct7=0000001) as MULDIV.
module inst_decoder
  import decode_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [31:0]      inst,
  output ctrl_bundle_t     ctrl,
  output logic [REG_W-1:0] rs1,
  output logic [REG_W-1:0] rs2,
  output logic [REG_W-1:0] rd,
  output logic             rs1_used,
  output logic             rs2_used,
  output logic             is_system
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];
  assign rs1    = REG_W'(inst[19:15]);
  assign rs2    = REG_W'(inst[24:20]);
  assign rd     = REG_W'(inst[11:7]);

  always_comb begin
    ctrl        = '0;
    ctrl.funct3 = funct3;
    rs1_used    = 1'b0;
    rs2_used    = 1'b0;
    is_system   = 1'b0;
    case (opcode)
      OP_LUI: begin
        ctrl.imm_type = IMM_U; ctrl.alu_op = ALU_LUI; ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1;
      end
      OP_AUIPC: begin
        ctrl.imm_type = IMM_U; ctrl.alu_op = ALU_ADD; ctrl.pc_to_reg_src = 1'b1; ctrl.reg_write = 1'b1;
      end
      OP_JAL: begin
        ctrl.imm_type = IMM_J; ctrl.alu_op = ALU_ADD; ctrl.pc_to_reg_src = 1'b1;
        ctrl.reg_write = 1'b1; ctrl.branch = BR_J;
      end
      OP_JALR: begin
        ctrl.imm_type = IMM_I; ctrl.alu_op = ALU_JALR; ctrl.alu_src = 1'b1; ctrl.pc_to_reg_src = 1'b1;
        ctrl.reg_write = 1'b1; ctrl.branch = BR_JALR; rs1_used = 1'b1;
      end
      OP_BRANCH: begin
        ctrl.imm_type = IMM_B; ctrl.alu_op = ALU_B; ctrl.branch = BR_B;
        rs1_used = 1'b1; rs2_used = 1'b1;
      end
      OP_LOAD: begin
        ctrl.imm_type = IMM_I; ctrl.alu_op = ALU_ADD; ctrl.alu_src = 1'b1; ctrl.mem_read = 1'b1;
        ctrl.mem_to_reg = 1'b1; ctrl.reg_write = 1'b1; rs1_used = 1'b1;
      end
      OP_STORE: begin
        ctrl.imm_type = IMM_S; ctrl.alu_op = ALU_ADD; ctrl.alu_src = 1'b1; ctrl.mem_write = 1'b1;
        rs1_used = 1'b1; rs2_used = 1'b1;
      end
      OP_IMM: begin
        ctrl.imm_type = IMM_I; ctrl.alu_op = ALU_I; ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1;
        rs1_used = 1'b1;
        // Only the shift-immediates carry a funct7 field.
        if (funct3 == 3'b001 && funct7 != 7'b0000000) ctrl.illegal = 1'b1;
        if (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000) ctrl.illegal = 1'b1;
      end
      OP_REG: begin
        ctrl.alu_op = ALU_R; ctrl.reg_write = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1;
        case (funct7)
          7'b0000000: ;
          7'b0100000: if (funct3 != 3'b000 && funct3 != 3'b101) ctrl.illegal = 1'b1;
`ifdef DECODE_MEXT_EN
          7'b0000001: ctrl.alu_op = ALU_MULDIV;
`endif
          default:    ctrl.illegal = 1'b1;
        endcase
      end
      OP_FENCE: ;
      OP_SYSTEM: begin
        is_system = 1'b1;
        if (funct3 == 3'b000 || funct3 == 3'b100) begin
          ctrl.illegal = 1'b1;
        end else begin
          ctrl.imm_type = IMM_C; ctrl.rd_src = 1'b1; ctrl.reg_write = 1'b1; ctrl.csr_write = 1'b1;
          rs1_used = ~funct3[2];
        end
      end
      default: ctrl.illegal = 1'b1;
    endcase
    if (ctrl.illegal) begin
      ctrl.reg_write  = 1'b0;
      ctrl.mem_read   = 1'b0;
      ctrl.mem_write  = 1'b0;
      ctrl.mem_to_reg = 1'b0;
      ctrl.csr_write  = 1'b0;
      ctrl.branch     = BR_NONE;
      rs1_used        = 1'b0;
      rs2_used        = 1'b0;
    end
  end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// ID/EX control register with load-use stall, flush, and SYSTEM serialisation.
// DECODE_MEXT_EN (decoder) enables MULDIV decode.
module decode_ctrl_pipe
  import decode_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int REG_W        = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [31:0]      id_inst,
  output logic             id_ready,
  input  logic             ex_ready,
  input  logic             flush,
  output logic             ex_valid,
  output logic [2:0]       ex_imm_type,
  output logic [2:0]       ex_alu_op,
  output logic             ex_pc_to_reg_src,
  output logic             ex_alu_src,
  output logic             ex_rd_src,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_mem_to_reg,
  output logic             ex_reg_write,
  output logic             ex_csr_write,
  output logic [1:0]       ex_branch,
  output logic [REG_W-1:0] ex_rs1,
  output logic [REG_W-1:0] ex_rs2,
  output logic [REG_W-1:0] ex_rd,
  output logic [2:0]       ex_funct3,
  output logic             ex_illegal
);

  localparam logic [2:0] DRAIN_INIT = 3'(DRAIN_CYCLES - 1);

  ctrl_bundle_t     dec, ex_q;
  logic [REG_W-1:0] dec_rs1, dec_rs2, dec_rd;
  logic [REG_W-1:0] rs1_q, rs2_q, rd_q;
  logic             rs1_used, rs2_used, is_system;
  logic             vld_q, hazard, permit, accept;
  fsm_state_e       state;
  logic [2:0]       cnt;

  inst_decoder #(.REG_W(REG_W)) u_dec (
    .inst      (id_inst),
    .ctrl      (dec),
    .rs1       (dec_rs1),
    .rs2       (dec_rs2),
    .rd        (dec_rd),
    .rs1_used  (rs1_used),
    .rs2_used  (rs2_used),
    .is_system (is_system)
  );

  assign hazard = vld_q & ex_q.mem_read & (rd_q != '0) &
                  ((rs1_used & (dec_rs1 == rd_q)) | (rs2_used & (dec_rs2 == rd_q)));

  always_comb begin
    permit = 1'b0;
    unique case (state)
      ST_IDLE:  permit = ~(id_valid & is_system);
      ST_DRAIN: permit = 1'b0;
      ST_ISSUE: permit = 1'b1;
      default:  permit = 1'b0;
    endcase
  end

  assign id_ready = ~rst & ex_ready & ~flush & ~hazard & permit;
  assign accept   = id_valid & id_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= 1'b0;
      ex_q  <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      rd_q  <= '0;
      state <= ST_IDLE;
      cnt   <= '0;
    end else if (flush) begin
      vld_q <= 1'b0;
      ex_q  <= bubble(ex_q);
      state <= ST_IDLE;
      cnt   <= '0;
    end else if (ex_ready) begin
      vld_q <= accept;
      ex_q  <= accept ? dec : bubble(dec);
      rs1_q <= dec_rs1;
      rs2_q <= dec_rs2;
      rd_q  <= dec_rd;
      // Drain counts only ex_ready cycles, so each step here is one bubble.
      unique case (state)
        ST_IDLE: if (id_valid && is_system) begin
          cnt   <= DRAIN_INIT;
          state <= (DRAIN_INIT == 3'd0) ? ST_ISSUE : ST_DRAIN;
        end
        ST_DRAIN: if (cnt == 3'd1) begin
          cnt   <= '0;
          state <= ST_ISSUE;
        end else begin
          cnt   <= cnt - 3'd1;
        end
        ST_ISSUE: if (accept) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign ex_valid         = vld_q;
  assign ex_imm_type      = ex_q.imm_type;
  assign ex_alu_op        = ex_q.alu_op;
  assign ex_pc_to_reg_src = ex_q.pc_to_reg_src;
  assign ex_alu_src       = ex_q.alu_src;
  assign ex_rd_src        = ex_q.rd_src;
  assign ex_mem_read      = ex_q.mem_read;
  assign ex_mem_write     = ex_q.mem_write;
  assign ex_mem_to_reg    = ex_q.mem_to_reg;
  assign ex_reg_write     = ex_q.reg_write;
  assign ex_csr_write     = ex_q.csr_write;
  assign ex_branch        = ex_q.branch;
  assign ex_funct3        = ex_q.funct3;
  assign ex_illegal       = ex_q.illegal;
  assign ex_rs1           = rs1_q;
  assign ex_rs2           = rs2_q;
  assign ex_rd            = rd_q;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Directed bench for decode_ctrl_pipe: decode, load-use, SYSTEM drain, stall, flush, reset.
module tb_decode_ctrl_pipe;

  localparam logic [31:0] I_ADD   = 32'h002081B3; // add x3,x1,x2
  localparam logic [31:0] I_LW5   = 32'h0000A283; // lw x5,0(x1)
  localparam logic [31:0] I_LW0   = 32'h0000A003; // lw x0,0(x1)
  localparam logic [31:0] I_DEP   = 32'h00228333; // add x6,x5,x2
  localparam logic [31:0] I_CSR   = 32'hB00020F3; // csrrs x1,0xb00,x0
  localparam logic [31:0] I_MUL   = 32'h022081B3; // mul x3,x1,x2
  localparam logic [31:0] I_SUB   = 32'h40208133; // sub x2,x1,x2
  localparam logic [31:0] I_BADF7 = 32'h40209133; // sll with funct7=0100000
  localparam logic [31:0] I_BADOP = 32'h0000007F;

  logic        clk = 1'b0;
  logic        rst, id_valid, ex_ready, flush, id_ready, ex_valid;
  logic [31:0] id_inst;
  logic [2:0]  ex_imm_type, ex_alu_op, ex_funct3;
  logic        ex_pc_to_reg_src, ex_alu_src, ex_rd_src;
  logic        ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_csr_write, ex_illegal;
  logic [1:0]  ex_branch;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;

  int errors = 0;
  int checks = 0;

  decode_ctrl_pipe #(.DRAIN_CYCLES(3), .REG_W(5)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_inst(id_inst), .id_ready(id_ready),
    .ex_ready(ex_ready), .flush(flush), .ex_valid(ex_valid), .ex_imm_type(ex_imm_type),
    .ex_alu_op(ex_alu_op), .ex_pc_to_reg_src(ex_pc_to_reg_src), .ex_alu_src(ex_alu_src),
    .ex_rd_src(ex_rd_src), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write), .ex_csr_write(ex_csr_write),
    .ex_branch(ex_branch), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_funct3(ex_funct3), .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs with a SYSTEM instruction presented; counts bubbles until it lands in EX.
  task automatic drain_run(output int bubbles, output bit found);
    bubbles = 0;
    found   = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (ex_valid) begin
        id_valid = 1'b0;
        found    = 1'b1;
        break;
      end
      bubbles++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; id_valid = 1'b1; id_inst = I_ADD; ex_ready = 1'b1; flush = 1'b0;
    tick(); tick();
    checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL reset_id_ready: got %0b want 0", id_ready); end
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid: got %0b want 0", ex_valid); end
    checks++; if ({ex_imm_type, ex_alu_op, ex_reg_write, ex_branch, ex_rd, ex_rs1, ex_illegal} !== '0) begin
      errors++; $display("FAIL reset_bundle: got %0h want 0", {ex_imm_type, ex_alu_op, ex_reg_write, ex_branch, ex_rd, ex_rs1, ex_illegal});
    end
    id_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    id_valid = 1'b1; id_inst = I_ADD;
    #1;
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL basic_ready: got %0b want 1", id_ready); end
    tick();
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %0b want 1", ex_valid); end
    checks++; if (ex_alu_op !== 3'b000) begin errors++; $display("FAIL basic_alu_op: got %0b want 000", ex_alu_op); end
    checks++; if (ex_reg_write !== 1'b1) begin errors++; $display("FAIL basic_reg_write: got %0b want 1", ex_reg_write); end
    checks++; if ({ex_rd, ex_rs1, ex_rs2} !== {5'd3, 5'd1, 5'd2}) begin
      errors++; $display("FAIL basic_regs: got rd=%0d rs1=%0d rs2=%0d want 3/1/2", ex_rd, ex_rs1, ex_rs2);
    end
    id_valid = 1'b0;
    tick();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL basic_drain: got %0b want 0", ex_valid); end
  endtask

  task automatic test_load_use();
    id_valid = 1'b1; id_inst = I_LW5;
    tick();
    checks++; if ({ex_valid, ex_mem_read, ex_mem_to_reg, ex_rd} !== {3'b111, 5'd5}) begin
      errors++; $display("FAIL lw_bundle: got v=%0b mr=%0b m2r=%0b rd=%0d want 1/1/1/5", ex_valid, ex_mem_read, ex_mem_to_reg, ex_rd);
    end
    id_inst = I_DEP;
    #1;
    checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL hazard_ready: got %0b want 0", id_ready); end
    tick();
    checks++; if ({ex_valid, ex_mem_read, ex_reg_write} !== 3'b000) begin
      errors++; $display("FAIL hazard_bubble: got v=%0b mr=%0b rw=%0b want 0/0/0", ex_valid, ex_mem_read, ex_reg_write);
    end
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL hazard_release: got %0b want 1", id_ready); end
    tick();
    checks++; if ({ex_valid, ex_rd} !== {1'b1, 5'd6}) begin
      errors++; $display("FAIL hazard_dep: got v=%0b rd=%0d want 1/6", ex_valid, ex_rd);
    end
    id_inst = I_LW0;
    tick();
    id_inst = I_DEP;
    #1;
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL lw_x0_ready: got %0b want 1", id_ready); end
    tick();
    checks++; if ({ex_valid, ex_rd} !== {1'b1, 5'd6}) begin
      errors++; $display("FAIL lw_x0_nobubble: got v=%0b rd=%0d want 1/6", ex_valid, ex_rd);
    end
    id_valid = 1'b0;
    tick();
  endtask

  task automatic test_csr_drain();
    int  nb;
    bit  ok;
    id_valid = 1'b1; id_inst = I_ADD;
    tick();
    id_inst = I_CSR;
    #1;
    checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL csr_blocked: got %0b want 0", id_ready); end
    drain_run(nb, ok);
    checks++; if (!ok) begin errors++; $display("FAIL csr_timeout: got no issue want issue within 12 cycles"); end
    checks++; if (nb != 3) begin errors++; $display("FAIL csr_bubbles: got %0d want 3", nb); end
    checks++; if ({ex_csr_write, ex_imm_type, ex_reg_write, ex_rd} !== {1'b1, 3'b101, 1'b1, 5'd1}) begin
      errors++; $display("FAIL csr_bundle: got cw=%0b imm=%0b rw=%0b rd=%0d want 1/101/1/1", ex_csr_write, ex_imm_type, ex_reg_write, ex_rd);
    end
    tick();
  endtask

  task automatic test_stall();
    id_valid = 1'b1; id_inst = I_ADD;
    tick();
    ex_ready = 1'b0; id_inst = I_LW5;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d]: got %0b want 0", i, id_ready); end
      tick();
      checks++; if ({ex_valid, ex_rd, ex_mem_read, ex_reg_write} !== {1'b1, 5'd3, 1'b0, 1'b1}) begin
        errors++; $display("FAIL stall_hold[%0d]: got v=%0b rd=%0d mr=%0b want 1/3/0", i, ex_valid, ex_rd, ex_mem_read);
      end
    end
    ex_ready = 1'b1;
    tick();
    checks++; if ({ex_valid, ex_rd, ex_mem_read} !== {1'b1, 5'd5, 1'b1}) begin
      errors++; $display("FAIL stall_release: got v=%0b rd=%0d mr=%0b want 1/5/1", ex_valid, ex_rd, ex_mem_read);
    end
    id_valid = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    int nb;
    bit ok;
    id_valid = 1'b1; id_inst = I_CSR;
    tick();
    flush = 1'b1;
    #1;
    checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %0b want 0", id_ready); end
    tick();
    flush = 1'b0;
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %0b want 0", ex_valid); end
    drain_run(nb, ok);
    checks++; if (!ok || nb != 3) begin errors++; $display("FAIL flush_redrain: got bubbles=%0d issued=%0b want 3/1", nb, ok); end
    // flush beats a stalled EX holding a valid bundle
    id_valid = 1'b1; id_inst = I_ADD;
    tick();
    ex_ready = 1'b0; flush = 1'b1; id_valid = 1'b0;
    tick();
    checks++; if ({ex_valid, ex_reg_write} !== 2'b00) begin
      errors++; $display("FAIL flush_over_stall: got v=%0b rw=%0b want 0/0", ex_valid, ex_reg_write);
    end
    ex_ready = 1'b1; flush = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    int nb;
    bit ok;
    id_valid = 1'b1; id_inst = I_CSR;
    tick();
    #2 rst = 1'b1;
    #1;
    checks++; if ({ex_rd, ex_imm_type} !== 8'h00) begin
      errors++; $display("FAIL async_rst_bundle: got rd=%0d imm=%0b want 0/0", ex_rd, ex_imm_type);
    end
    checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL async_rst_ready: got %0b want 0", id_ready); end
    #1 rst = 1'b0;
    drain_run(nb, ok);
    checks++; if (!ok || nb != 3) begin errors++; $display("FAIL async_rst_redrain: got bubbles=%0d issued=%0b want 3/1", nb, ok); end
    tick();
  endtask

  task automatic test_decode_edge();
    id_valid = 1'b1; id_inst = I_MUL;
    tick();
`ifdef DECODE_MEXT_EN
    checks++; if ({ex_valid, ex_alu_op, ex_illegal, ex_reg_write} !== {1'b1, 3'b110, 1'b0, 1'b1}) begin
      errors++; $display("FAIL mul_decode: got v=%0b alu=%0b ill=%0b rw=%0b want 1/110/0/1", ex_valid, ex_alu_op, ex_illegal, ex_reg_write);
    end
`else
    checks++; if ({ex_valid, ex_illegal, ex_reg_write} !== 3'b110) begin
      errors++; $display("FAIL mul_illegal: got v=%0b ill=%0b rw=%0b want 1/1/0", ex_valid, ex_illegal, ex_reg_write);
    end
    checks++; if (ex_alu_op === 3'b110) begin errors++; $display("FAIL mul_aluop: got 110 want not 110"); end
`endif
    id_inst = I_SUB;
    tick();
    checks++; if ({ex_illegal, ex_reg_write, ex_alu_op} !== {1'b0, 1'b1, 3'b000}) begin
      errors++; $display("FAIL sub_decode: got ill=%0b rw=%0b alu=%0b want 0/1/000", ex_illegal, ex_reg_write, ex_alu_op);
    end
    id_inst = I_BADF7;
    tick();
    checks++; if ({ex_illegal, ex_reg_write} !== 2'b10) begin
      errors++; $display("FAIL bad_funct7: got ill=%0b rw=%0b want 1/0", ex_illegal, ex_reg_write);
    end
    id_inst = I_BADOP;
    tick();
    checks++; if ({ex_valid, ex_illegal, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch} !== 7'b1100000) begin
      errors++; $display("FAIL bad_opcode: got v=%0b ill=%0b rw=%0b br=%0b want 1/1/0/00", ex_valid, ex_illegal, ex_reg_write, ex_branch);
    end
    id_valid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_load_use();
    test_csr_drain();
    test_stall();
    test_flush();
    test_async_reset();
    test_decode_edge();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
